// File: rtl/bus_addr_dec_pipe.sv
// rtl/bus_addr_dec_pipe.sv - pipelined one-hot slave address decoder with default error slave
module bus_addr_dec_pipe #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int SEL_W  = 3,
    parameter int N_SLV  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    m_req,
    input  logic [ADDR_W-1:0]       m_addr,
    output logic                    m_ready,
    output logic                    m_resp,
    output logic [DATA_W-1:0]       m_rdata,
    output logic [N_SLV-1:0]        S_sel,
    input  logic [N_SLV*DATA_W-1:0] s_rdata,
    input  logic [N_SLV-1:0]        s_ready,
    output logic [7:0]              err_count,
    output logic [ADDR_W-1:0]       err_addr
);

    localparam int NUM = 1 << SEL_W;

    typedef enum logic [1:0] {IDLE, ERR1, ERR2} state_t;

    state_t              state, state_nxt;
    logic [SEL_W-1:0]    idx;
    logic [SEL_W-1:0]    dp_idx;
    logic                mapped;
    logic                accept;
    logic                dp_valid;
    logic                dp_map;
    logic [NUM-1:0]      ready_pad;
    logic [NUM*DATA_W-1:0] rdata_pad;

    assign idx    = m_addr[ADDR_W-1 -: SEL_W];
    assign mapped = ({1'b0, idx} < (SEL_W+1)'(N_SLV));

    // Pad the slave buses to the full decode space so dp_idx never indexes out of range.
    assign ready_pad = NUM'(s_ready);
    assign rdata_pad = (NUM*DATA_W)'(s_rdata);

    always_comb begin
        state_nxt = state;
        m_ready   = 1'b1;
        m_resp    = 1'b0;
        m_rdata   = '0;
        S_sel     = '0;
        accept    = 1'b0;

        case (state)
            ERR1:    begin m_ready = 1'b0; m_resp = 1'b1; end
            ERR2:    begin m_ready = 1'b1; m_resp = 1'b1; end
            default: begin
                if (dp_valid && dp_map) begin
                    m_ready = ready_pad[dp_idx];
                end
            end
        endcase

        if (dp_valid && dp_map) begin
            m_rdata = rdata_pad[dp_idx*DATA_W +: DATA_W];
        end

        accept = m_req && m_ready;

        for (int i = 0; i < N_SLV; i++) begin
            S_sel[i] = accept && mapped && (idx == SEL_W'(i));
        end

        case (state)
            IDLE:    if (accept && !mapped) state_nxt = ERR1;
            ERR1:    state_nxt = ERR2;
            ERR2:    state_nxt = (accept && !mapped) ? ERR1 : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            dp_valid  <= 1'b0;
            dp_map    <= 1'b0;
            dp_idx    <= '0;
            err_count <= '0;
            err_addr  <= '0;
        end else begin
            state <= state_nxt;
            if (m_ready) begin
                dp_valid <= m_req;
                dp_idx   <= idx;
                dp_map   <= mapped;
            end
            if (accept && !mapped) begin
                err_addr <= m_addr;
                if (err_count != 8'hFF) begin
                    err_count <= err_count + 8'd1;
                end
            end
        end
    end

endmodule
